mem_access_ctrl: RTL and testbench

Sequences CPU memory requests onto the program ROM and the external-style RAM, both built from the team's single-port `Memory` block (1-cycle registered read on `strobe`, write echoes `dataIn`). It sits directly upstream of those two instances. It decodes the 16-bit CPU address into ROM, RAM or unmapped space, drives each memory's `addr`/`strobe`/`write`, and inserts programmable RAM wait states. It returns read data with a single-cycle `cpuDone` pulse.

---
 rtl/mem_access_ctrl_pkg.sv | 24 ++
 rtl/mem_region_decode.sv | 30 +++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default constants for the CPU memory access path.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_ROM  = 2'd1,
    REG_RAM  = 2'd2
  } region_t;

  // Defaults used by the CPU top level address map.
  localparam int          DEF_ROM_ADDR_WIDTH = 11;
  localparam int          DEF_RAM_ADDR_WIDTH = 12;
  localparam logic [15:0] DEF_RAM_BASE       = 16'h0800;
  localparam int          DEF_RAM_WAIT       = 1;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: CPU address to region code and RAM offset.
// Compares are done in 17 bits so the end of the RAM window never wraps.
module mem_region_decode
  import mem_access_ctrl_pkg::*;
#(
  parameter int          romAddrWidth = DEF_ROM_ADDR_WIDTH,
  parameter int          ramAddrWidth = DEF_RAM_ADDR_WIDTH,
  parameter logic [15:0] ramBase      = DEF_RAM_BASE
) (
  input  logic [15:0]             addr,
  output region_t                 region,
  output logic [ramAddrWidth-1:0] ramOffset
);

  localparam logic [16:0] ROM_TOP = 17'(2 ** romAddrWidth);
  localparam logic [16:0] RAM_LO  = {1'b0, ramBase};
  localparam logic [16:0] RAM_HI  = RAM_LO + 17'(2 ** ramAddrWidth);

  // ROM takes priority; anything outside both windows is unmapped.
  always_comb begin
    region    = REG_NONE;
    ramOffset = ramAddrWidth'(addr - ramBase);
    if ({1'b0, addr} < ROM_TOP) begin
      region = REG_ROM;
    end else if (({1'b0, addr} >= RAM_LO) && ({1'b0, addr} < RAM_HI)) begin
      region = REG_RAM;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU memory access sequencer for the program ROM and the wait-stated RAM.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | waiting for cpuReq; cpuDone pulses here after completion
//  ST_STROBE  | one-cycle strobe to the selected memory
//  ST_WAIT    | RAM wait states, counted down by wait_cnt
//  ST_CAPTURE | memory data valid; registered into cpuDataOut on exit
//  ST_FAULT   | ROM write or unmapped address; returns 8'hFF with fault
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int          romAddrWidth  = DEF_ROM_ADDR_WIDTH,
  parameter int          ramAddrWidth  = DEF_RAM_ADDR_WIDTH,
  parameter logic [15:0] ramBase       = DEF_RAM_BASE,
  parameter int          ramWaitStates = DEF_RAM_WAIT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpuReq,
  input  logic [15:0]             cpuAddr,
  input  logic                    cpuWrite,
  input  logic [7:0]              cpuDataIn,
  output logic                    cpuBusy,
  output logic                    cpuDone,
  output logic [7:0]              cpuDataOut,
  output logic                    cpuFault,
  output logic [romAddrWidth-1:0] romAddr,
  output logic                    romStrobe,
  input  logic [7:0]              romDataIn,
  output logic [ramAddrWidth-1:0] ramAddr,
  output logic                    ramStrobe,
  output logic                    ramWrite,
  output logic [7:0]              ramDataOut,
  input  logic [7:0]              ramDataIn
);

  if (int'(ramBase) < (2 ** romAddrWidth)) begin : g_bad_base
    $error("mem_access_ctrl: ramBase overlaps the ROM region");
  end
  if ((ramWaitStates < 0) || (ramWaitStates > 15)) begin : g_bad_wait
    $error("mem_access_ctrl: ramWaitStates must be 0..15");
  end

  localparam logic [3:0] WAIT_CNT = 4'(ramWaitStates);

  state_t                  state, state_next;
  region_t                 region_q, dec_region;
  logic                    write_q;
  logic [3:0]              wait_cnt;
  logic [ramAddrWidth-1:0] dec_offset;

  mem_region_decode #(
    .romAddrWidth(romAddrWidth),
    .ramAddrWidth(ramAddrWidth),
    .ramBase     (ramBase)
  ) u_decode (
    .addr     (cpuAddr),
    .region   (dec_region),
    .ramOffset(dec_offset)
  );

  assign cpuBusy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and memory strobes.
  always_comb begin
    state_next = state;
    romStrobe  = 1'b0;
    ramStrobe  = 1'b0;
    ramWrite   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpuReq) begin
          if ((dec_region == REG_RAM) || ((dec_region == REG_ROM) && !cpuWrite))
            state_next = ST_STROBE;
          else
            state_next = ST_FAULT;
        end
      end
      ST_STROBE: begin
        romStrobe = (region_q == REG_ROM);
        ramStrobe = (region_q == REG_RAM);
        ramWrite  = (region_q == REG_RAM) && write_q;
        if ((region_q == REG_RAM) && (WAIT_CNT != 4'd0)) state_next = ST_WAIT;
        else                                             state_next = ST_CAPTURE;
      end
      ST_WAIT:    if (wait_cnt == 4'd0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      ST_FAULT:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Request latch: addresses and write data stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q   <= REG_NONE;
      write_q    <= 1'b0;
      romAddr    <= '0;
      ramAddr    <= '0;
      ramDataOut <= 8'h00;
    end else if ((state == ST_IDLE) && cpuReq) begin
      region_q   <= dec_region;
      write_q    <= cpuWrite;
      romAddr    <= cpuAddr[romAddrWidth-1:0];
      ramAddr    <= dec_offset;
      ramDataOut <= cpuDataIn;
    end
  end

  // Wait-state down-counter; loaded in STROBE so WAIT lasts WAIT_CNT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if ((state == ST_STROBE) && (WAIT_CNT != 4'd0)) begin
      wait_cnt <= WAIT_CNT - 4'd1;
    end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Completion response: one-cycle cpuDone, data and fault held until next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpuDone    <= 1'b0;
      cpuFault   <= 1'b0;
      cpuDataOut <= 8'h00;
    end else begin
      cpuDone <= 1'b0;
      if (state == ST_CAPTURE) begin
        cpuDone    <= 1'b1;
        cpuFault   <= 1'b0;
        cpuDataOut <= (region_q == REG_ROM) ? romDataIn : ramDataIn;
      end else if (state == ST_FAULT) begin
        cpuDone    <= 1'b1;
        cpuFault   <= 1'b1;
        cpuDataOut <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with behavioural ROM/RAM models.
module tb_mem_access_ctrl;

  localparam int WS      = 1;
  localparam int ROM_SZ  = 2048;
  localparam int RAM_SZ  = 4096;
  localparam int RAM_LO  = 16'h0800;
  localparam int K_ROM   = 0;
  localparam int K_RAM   = 1;
  localparam int K_FAULT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpuReq = 1'b0;
  logic [15:0] cpuAddr = '0;
  logic        cpuWrite = 1'b0;
  logic [7:0]  cpuDataIn = '0;
  logic        cpuBusy, cpuDone, cpuFault;
  logic [7:0]  cpuDataOut;
  logic [10:0] romAddr;
  logic        romStrobe;
  logic [7:0]  romDataIn;
  logic [11:0] ramAddr;
  logic        ramStrobe, ramWrite;
  logic [7:0]  ramDataOut, ramDataIn;

  mem_access_ctrl #(
    .romAddrWidth(11), .ramAddrWidth(12), .ramBase(16'h0800), .ramWaitStates(WS)
  ) dut (
    .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuAddr(cpuAddr),
    .cpuWrite(cpuWrite), .cpuDataIn(cpuDataIn), .cpuBusy(cpuBusy),
    .cpuDone(cpuDone), .cpuDataOut(cpuDataOut), .cpuFault(cpuFault),
    .romAddr(romAddr), .romStrobe(romStrobe), .romDataIn(romDataIn),
    .ramAddr(ramAddr), .ramStrobe(ramStrobe), .ramWrite(ramWrite),
    .ramDataOut(ramDataOut), .ramDataIn(ramDataIn)
  );

  always #5 clk = ~clk;

  // Memory models: registered read on strobe, write echoes the written data.
  logic [7:0] rom_mem [ROM_SZ];
  logic [7:0] ram_mem [RAM_SZ];
  logic [7:0] rom_q = 8'h00, ram_q = 8'h00;
  assign romDataIn = rom_q;
  assign ramDataIn = ram_q;
  always @(posedge clk) begin
    if (romStrobe) rom_q <= rom_mem[romAddr];
    if (ramStrobe) begin
      if (ramWrite) begin
        ram_mem[ramAddr] <= ramDataOut;
        ram_q            <= ramDataOut;
      end else begin
        ram_q <= ram_mem[ramAddr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rom_ref [ROM_SZ];
  logic [7:0] ram_ref [RAM_SZ];
  int n_cmp = 0, n_bad = 0;
  int last_acc = 0, last_done = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: strobe placement and completion checking against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && cyc == exp_q[0].acc + 1) begin
        exp_t e;
        e = exp_q[0];
        chk("rom_strobe", int'(romStrobe), int'(e.kind == K_ROM));
        chk("ram_strobe", int'(ramStrobe), int'(e.kind == K_RAM));
        chk("ram_write", int'(ramWrite), int'(e.kind == K_RAM && e.wr));
        if (e.kind == K_ROM) chk("rom_addr", int'(romAddr), int'(e.addr) % ROM_SZ);
        if (e.kind == K_RAM) begin
          chk("ram_addr", int'(ramAddr), int'(e.addr) - RAM_LO);
          if (e.wr) chk("ram_wdata", int'(ramDataOut), int'(e.data));
        end
      end else if (romStrobe || ramStrobe) begin
        chk("stray_strobe", int'({romStrobe, ramStrobe}), 0);
      end
      if (cpuDone) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_latency", cyc - e.acc, e.lat);
          chk("done_data", int'(cpuDataOut), int'(e.data));
          chk("done_fault", int'(cpuFault), int'(e.kind == K_FAULT));
          chk("done_busy", int'(cpuBusy), 0);
          last_done = cyc;
        end
      end
    end
  end

  // Drive one request once the DUT is idle; scribble on inputs while it is busy.
  task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (cpuBusy && n < 100) begin
      cpuReq    = 1'($urandom_range(0, 1));
      cpuAddr   = 16'($urandom);
      cpuWrite  = 1'($urandom);
      cpuDataIn = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (cpuBusy) begin
      chk("busy_timeout", 1, 0);
      return;
    end
    e.wr = w; e.addr = a; e.acc = cyc;
    if (int'(a) < ROM_SZ && !w) begin
      e.kind = K_ROM; e.data = rom_ref[int'(a)]; e.lat = 3;
    end else if (int'(a) >= RAM_LO && int'(a) < RAM_LO + RAM_SZ) begin
      e.kind = K_RAM; e.lat = 3 + WS;
      if (w) begin
        e.data = d;
        ram_ref[int'(a) - RAM_LO] = d;
      end else begin
        e.data = ram_ref[int'(a) - RAM_LO];
      end
    end else begin
      e.kind = K_FAULT; e.data = 8'hFF; e.lat = 2;
    end
    exp_q.push_back(e);
    last_acc  = cyc;
    cpuReq    = 1'b1;
    cpuAddr   = a;
    cpuWrite  = w;
    cpuDataIn = d;
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    cpuReq = 1'b0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int t0, bad_rom, bad_ram;
    logic [15:0] a;
    for (int i = 0; i < ROM_SZ; i++) begin
      rom_mem[i] = 8'($urandom);
      rom_ref[i] = rom_mem[i];
    end
    rom_mem[16'h123] = 8'h5A;
    rom_ref[16'h123] = 8'h5A;
    for (int i = 0; i < RAM_SZ; i++) begin
      ram_mem[i] = 8'h00;
      ram_ref[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(cpuBusy), 0);
    chk("rst_done", int'(cpuDone), 0);
    chk("rst_fault", int'(cpuFault), 0);
    chk("rst_dout", int'(cpuDataOut), 0);
    chk("rst_strobes", int'({romStrobe, ramStrobe, ramWrite}), 0);
    chk("rst_addrs", int'({romAddr, ramAddr, ramDataOut}), 0);

    issue(16'h0123, 1'b0, 8'h00);
    drain();
    issue(16'h0810, 1'b1, 8'hC3);
    issue(16'h0810, 1'b0, 8'h00);
    drain();
    issue(16'h0010, 1'b1, 8'h77);
    drain();
    issue(16'h1800, 1'b0, 8'h00);
    drain();
    issue(16'h07FF, 1'b0, 8'h00);
    issue(16'h0800, 1'b0, 8'h00);
    issue(16'h17FF, 1'b1, 8'h3C);
    issue(16'h17FF, 1'b0, 8'h00);
    issue(16'hFFFF, 1'b1, 8'h11);
    drain();

    issue(16'h0001, 1'b0, 8'h00);
    t0 = last_acc;
    issue(16'h0002, 1'b0, 8'h00);
    issue(16'h0003, 1'b0, 8'h00);
    drain();
    chk("b2b_span", last_done - t0, 9);

    // Reset during the WAIT cycle of a RAM read.
    issue(16'h0900, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    cpuReq = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", int'(cpuBusy), 0);
    chk("midrst_done", int'(cpuDone), 0);
    chk("midrst_dout", int'({cpuFault, cpuDataOut}), 0);
    chk("midrst_strobes", int'({romStrobe, ramStrobe, ramWrite}), 0);
    chk("midrst_addrs", int'({romAddr, ramAddr, ramDataOut}), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    issue(16'h0123, 1'b0, 8'h00);
    drain();

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: a = 16'($urandom_range(0, ROM_SZ - 1));
        1, 2: a = 16'($urandom_range(RAM_LO, RAM_LO + 63));
        3: a = 16'($urandom_range(RAM_LO + RAM_SZ, 16'hFFFF));
        default: a = 16'($urandom_range(RAM_LO, RAM_LO + RAM_SZ - 1));
      endcase
      issue(a, 1'($urandom), 8'($urandom));
    end
    drain();

    bad_rom = 0;
    bad_ram = 0;
    for (int i = 0; i < ROM_SZ; i++) if (rom_mem[i] !== rom_ref[i]) bad_rom++;
    for (int i = 0; i < RAM_SZ; i++) if (ram_mem[i] !== ram_ref[i]) bad_ram++;
    chk("rom_contents", bad_rom, 0);
    chk("ram_contents", bad_ram, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
